// File: rtl/config_ram_arb_pkg.sv
// rtl/config_ram_arb_pkg.sv - shared types for the config RAM arbiter
package config_ram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester index: 0 = r0, 1 = r1.
  typedef logic req_id_t;

endpackage

// File: rtl/config_ram_arb_pick.sv
// rtl/config_ram_arb_pick.sv - winner selection; round-robin when CONFIG_RAM_ARB_RR_EN is defined
module config_ram_arb_pick
  import config_ram_arb_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
`ifdef CONFIG_RAM_ARB_RR_EN
  input  req_id_t last,
`endif
  output req_id_t pick
);

`ifdef CONFIG_RAM_ARB_RR_EN
  // A lone requester wins outright; on contention the side not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
  end
`else
  // Fixed priority: r1 only wins when r0 is quiet.
  assign pick = req1 & ~req0;
`endif

endmodule

// File: rtl/config_ram_arbiter.sv
// rtl/config_ram_arbiter.sv - two-requester arbiter for one config RAM (CONFIG_RAM_ARB_RR_EN selects round-robin)
module config_ram_arbiter
  import config_ram_arb_pkg::*;
#(
  parameter int N_BYTES   = 4,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int N_BITS    = N_BYTES * 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [N_BITS-1:0]    r0_wdata,
  input  logic [ADDR_BITS-1:0] r0_addr,
  input  logic [N_BYTES-1:0]   r0_byte_en,
  input  logic                 r0_wen,
  input  logic                 r0_ren,
  output logic [N_BITS-1:0]    r0_rdata,
  output logic                 r0_busy,
  input  logic [N_BITS-1:0]    r1_wdata,
  input  logic [ADDR_BITS-1:0] r1_addr,
  input  logic [N_BYTES-1:0]   r1_byte_en,
  input  logic                 r1_wen,
  input  logic                 r1_ren,
  output logic [N_BITS-1:0]    r1_rdata,
  output logic                 r1_busy,
  output logic [N_BITS-1:0]    ram_wdata,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [N_BYTES-1:0]   ram_byte_en,
  output logic                 ram_wen,
  output logic                 ram_ren,
  input  logic [N_BITS-1:0]    ram_rdata,
  input  logic                 ram_busy
);

  arb_state_t state;
  req_id_t    owner;
  req_id_t    pick;
  req_id_t    winner;
  logic       req0, req1;
  logic       win_req;
  logic       granted0, granted1;
  logic       complete;

  assign req0 = r0_wen | r0_ren;
  assign req1 = r1_wen | r1_ren;

`ifdef CONFIG_RAM_ARB_RR_EN
  req_id_t last;
`endif

  config_ram_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
`ifdef CONFIG_RAM_ARB_RR_EN
    .last (last),
`endif
    .pick (pick)
  );

  // The lock holder keeps the RAM until it completes; otherwise arbitrate live.
  // Holding reset forces the grant off so the RAM sees no strobes mid-reset.
  assign winner   = (state == LOCKED) ? owner : pick;
  assign win_req  = (winner ? req1 : req0) & nRST;
  assign granted0 = win_req & (winner == 1'b0);
  assign granted1 = win_req & (winner == 1'b1);
  assign complete = win_req & ~ram_busy;

  assign r0_busy  = req0 & ~(granted0 & ~ram_busy);
  assign r1_busy  = req1 & ~(granted1 & ~ram_busy);
  assign r0_rdata = ram_rdata;
  assign r1_rdata = ram_rdata;

  // RAM-side mux: granted requester's fields, all zero when nobody is granted.
  always_comb begin
    ram_wdata   = '0;
    ram_addr    = '0;
    ram_byte_en = '0;
    ram_wen     = 1'b0;
    ram_ren     = 1'b0;
    if (granted0) begin
      ram_wdata   = r0_wdata;
      ram_addr    = r0_addr;
      ram_byte_en = r0_byte_en;
      ram_wen     = r0_wen;
      ram_ren     = r0_ren;
    end else if (granted1) begin
      ram_wdata   = r1_wdata;
      ram_addr    = r1_addr;
      ram_byte_en = r1_byte_en;
      ram_wen     = r1_wen;
      ram_ren     = r1_ren;
    end
  end

  // Lock FSM: lock on a stalled access, release on completion or when the owner walks away.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_req && ram_busy) begin
            state <= LOCKED;
            owner <= pick;
          end
        end
        LOCKED: begin
          if (!win_req || !ram_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONFIG_RAM_ARB_RR_EN
  // Remember who finished last; reset to r1 so r0 takes the first contention.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last <= 1'b1;
    end else if (complete) begin
      last <= winner;
    end
  end
`else
  logic unused_complete;
  assign unused_complete = complete;
`endif

endmodule

// File: tb/tb_config_ram_arbiter.sv
// tb/tb_config_ram_arbiter.sv - directed self-checking bench for config_ram_arbiter
module tb_config_ram_arbiter;

  logic        CLK;
  logic        nRST;
  logic [31:0] r0_wdata, r1_wdata;
  logic [7:0]  r0_addr, r1_addr;
  logic [3:0]  r0_byte_en, r1_byte_en;
  logic        r0_wen, r0_ren, r1_wen, r1_ren;
  logic [31:0] r0_rdata, r1_rdata;
  logic        r0_busy, r1_busy;
  logic [31:0] ram_wdata;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_byte_en;
  logic        ram_wen, ram_ren;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  int errors = 0;
  int checks = 0;

  // RAM model: busy for lat cycles per access, completes in cycle lat+1.
  logic [31:0] mem [0:255];
  int lat = 0;
  int cnt;
  logic strobe;
  assign strobe    = ram_wen | ram_ren;
  assign ram_busy  = strobe && (cnt < lat);
  assign ram_rdata = mem[ram_addr];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt <= 0;
    else if (strobe && cnt < lat) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always @(posedge CLK) begin
    if (nRST && ram_wen && cnt >= lat) begin
      for (int b = 0; b < 4; b++)
        if (ram_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  config_ram_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .r0_wdata(r0_wdata), .r0_addr(r0_addr), .r0_byte_en(r0_byte_en),
    .r0_wen(r0_wen), .r0_ren(r0_ren), .r0_rdata(r0_rdata), .r0_busy(r0_busy),
    .r1_wdata(r1_wdata), .r1_addr(r1_addr), .r1_byte_en(r1_byte_en),
    .r1_wen(r1_wen), .r1_ren(r1_ren), .r1_rdata(r1_rdata), .r1_busy(r1_busy),
    .ram_wdata(ram_wdata), .ram_addr(ram_addr), .ram_byte_en(ram_byte_en),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_rdata(ram_rdata), .ram_busy(ram_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    r0_wen = 0; r0_ren = 0; r0_addr = 0; r0_wdata = 0; r0_byte_en = 0;
    r1_wen = 0; r1_ren = 0; r1_addr = 0; r1_wdata = 0; r1_byte_en = 0;
  endtask

  task automatic do_reset();
    clear_req();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic test_reset();
    clear_req();
    nRST = 0;
    #2;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL rst_ram_ren got=%0h exp=0", ram_ren); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL rst_ram_wen got=%0h exp=0", ram_wen); end
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL rst_ram_addr got=%0h exp=0", ram_addr); end
    checks++; if (r0_busy !== 1'b0 || r1_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b%0b exp=00", r0_busy, r1_busy); end
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic test_zero_latency();
    lat = 0;
    next_cycle();
    r0_wen = 1; r0_addr = 8'h10; r0_wdata = 32'hA5A5_1234; r0_byte_en = 4'hF;
    @(negedge CLK);
    checks++; if (ram_wen !== 1'b1 || r0_busy !== 1'b0) begin errors++; $display("FAIL zl_write got wen=%0b busy=%0b exp wen=1 busy=0", ram_wen, r0_busy); end
    next_cycle();
    clear_req(); r0_ren = 1; r0_addr = 8'h10;
    @(negedge CLK);
    checks++; if (ram_ren !== 1'b1) begin errors++; $display("FAIL zl_ram_ren got=%0b exp=1", ram_ren); end
    checks++; if (ram_addr !== 8'h10) begin errors++; $display("FAIL zl_ram_addr got=%0h exp=10", ram_addr); end
    checks++; if (r0_busy !== 1'b0) begin errors++; $display("FAIL zl_busy got=%0b exp=0", r0_busy); end
    checks++; if (r0_rdata !== 32'hA5A5_1234) begin errors++; $display("FAIL zl_rdata got=%0h exp=a5a51234", r0_rdata); end
    next_cycle();
    clear_req(); r0_wen = 1; r0_addr = 8'h10; r0_wdata = 32'h0000_00EE; r0_byte_en = 4'h1;
    next_cycle();
    clear_req(); r0_ren = 1; r0_addr = 8'h10;
    @(negedge CLK);
    checks++; if (r0_rdata !== 32'hA5A5_12EE) begin errors++; $display("FAIL zl_byte_en got=%0h exp=a5a512ee", r0_rdata); end
    next_cycle();
    clear_req();
  endtask

  task automatic test_back_to_back();
    lat = 2;
    r0_wen = 1; r0_addr = 8'h20; r0_wdata = 32'h1111_2222; r0_byte_en = 4'hF;
    r1_wen = 1; r1_addr = 8'h30; r1_wdata = 32'h3333_4444; r1_byte_en = 4'hF;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h20 || ram_wen !== 1'b1) begin errors++; $display("FAIL b2b_c0_grant got addr=%0h wen=%0b exp addr=20 wen=1", ram_addr, ram_wen); end
    checks++; if (r0_busy !== 1'b1 || r1_busy !== 1'b1) begin errors++; $display("FAIL b2b_c0_busy got=%0b%0b exp=11", r0_busy, r1_busy); end
    next_cycle();
    @(negedge CLK);
    checks++; if (r0_busy !== 1'b1 || r1_busy !== 1'b1) begin errors++; $display("FAIL b2b_c1_busy got=%0b%0b exp=11", r0_busy, r1_busy); end
    next_cycle();
    @(negedge CLK);
    checks++; if (r0_busy !== 1'b0 || r1_busy !== 1'b1) begin errors++; $display("FAIL b2b_c2_busy got=%0b%0b exp=01", r0_busy, r1_busy); end
    next_cycle();
    r0_wen = 0; r0_addr = 0;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h30 || r1_busy !== 1'b1) begin errors++; $display("FAIL b2b_c3_r1 got addr=%0h busy=%0b exp addr=30 busy=1", ram_addr, r1_busy); end
    repeat (2) next_cycle();
    @(negedge CLK);
    checks++; if (r1_busy !== 1'b0) begin errors++; $display("FAIL b2b_c5_busy got=%0b exp=0", r1_busy); end
    next_cycle();
    clear_req();
    checks++; if (mem[32] !== 32'h1111_2222) begin errors++; $display("FAIL b2b_mem20 got=%0h exp=11112222", mem[32]); end
    checks++; if (mem[48] !== 32'h3333_4444) begin errors++; $display("FAIL b2b_mem30 got=%0h exp=33334444", mem[48]); end
  endtask

  task automatic test_alternate();
    logic [7:0] exp;
    do_reset();
    lat = 0;
    r0_ren = 1; r0_addr = 8'h01;
    r1_ren = 1; r1_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
`ifdef CONFIG_RAM_ARB_RR_EN
      exp = (i % 2 == 0) ? 8'h01 : 8'h02;
`else
      exp = 8'h01;
`endif
      @(negedge CLK);
      checks++; if (ram_addr !== exp) begin errors++; $display("FAIL alt_grant%0d got=%0h exp=%0h", i, ram_addr, exp); end
    end
    next_cycle();
    clear_req();
  endtask

  task automatic test_lock_hold();
    lat = 2;
    r1_wen = 1; r1_addr = 8'h40; r1_wdata = 32'hCAFE_F00D; r1_byte_en = 4'hF;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h40) begin errors++; $display("FAIL lock_c0_addr got=%0h exp=40", ram_addr); end
    next_cycle();
    r0_ren = 1; r0_addr = 8'h50;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h40 || ram_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL lock_c1_hold got addr=%0h data=%0h exp addr=40 data=cafef00d", ram_addr, ram_wdata); end
    checks++; if (r0_busy !== 1'b1) begin errors++; $display("FAIL lock_c1_r0busy got=%0b exp=1", r0_busy); end
    next_cycle();
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h40 || r1_busy !== 1'b0) begin errors++; $display("FAIL lock_c2_done got addr=%0h busy=%0b exp addr=40 busy=0", ram_addr, r1_busy); end
    next_cycle();
    r1_wen = 0; r1_addr = 0; r1_wdata = 0;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h50 || ram_ren !== 1'b1) begin errors++; $display("FAIL lock_c3_r0 got addr=%0h ren=%0b exp addr=50 ren=1", ram_addr, ram_ren); end
    repeat (3) next_cycle();
    clear_req();
  endtask

  task automatic test_reset_mid();
    lat = 3;
    r1_ren = 1; r1_addr = 8'h60;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h60 || ram_ren !== 1'b1) begin errors++; $display("FAIL rmid_c0 got addr=%0h ren=%0b exp addr=60 ren=1", ram_addr, ram_ren); end
    next_cycle();
    r0_ren = 1; r0_addr = 8'h70;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h60) begin errors++; $display("FAIL rmid_locked got=%0h exp=60", ram_addr); end
    #1 nRST = 0;
    #1;
    checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin errors++; $display("FAIL rmid_strobes got ren=%0b wen=%0b exp 0 0", ram_ren, ram_wen); end
    next_cycle();
    nRST = 1;
    @(negedge CLK);
    checks++; if (ram_addr !== 8'h70 || ram_ren !== 1'b1) begin errors++; $display("FAIL rmid_r0_wins got addr=%0h ren=%0b exp addr=70 ren=1", ram_addr, ram_ren); end
    checks++; if (r1_busy !== 1'b1) begin errors++; $display("FAIL rmid_r1_busy got=%0b exp=1", r1_busy); end
    next_cycle();
    clear_req();
    repeat (2) next_cycle();
  endtask

  task automatic test_owner_drop();
    lat = 3;
    r0_ren = 1; r0_addr = 8'h11;
    @(negedge CLK);
    checks++; if (r0_busy !== 1'b1) begin errors++; $display("FAIL drop_c0_busy got=%0b exp=1", r0_busy); end
    next_cycle();
    @(negedge CLK);
    checks++; if (r0_busy !== 1'b1) begin errors++; $display("FAIL drop_c1_busy got=%0b exp=1", r0_busy); end
    next_cycle();
    r0_ren = 0; r0_addr = 0;
    r1_ren = 1; r1_addr = 8'h22;
    @(negedge CLK);
    checks++; if (ram_ren !== 1'b0 || r1_busy !== 1'b1) begin errors++; $display("FAIL drop_c2 got ren=%0b r1busy=%0b exp ren=0 r1busy=1", ram_ren, r1_busy); end
    next_cycle();
    @(negedge CLK);
    checks++; if (ram_ren !== 1'b1 || ram_addr !== 8'h22) begin errors++; $display("FAIL drop_idle got ren=%0b addr=%0h exp ren=1 addr=22", ram_ren, ram_addr); end
    next_cycle();
    clear_req();
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_back_to_back();
    test_alternate();
    test_lock_hold();
    test_reset_mid();
    test_owner_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_ram_arbiter.md
# config_ram_arbiter

Two-requester arbiter that shares one `config_ram_wrapper` instance between independent masters, e.g. a cache fill engine and a debug/config port. Each side uses the same strobe-plus-busy protocol as the RAM itself. The arbiter selects one requester and locks that grant until the RAM completes the access. It then multiplexes address, data and strobes to the RAM and returns `busy` and `rdata` to the requesters.

## Interface
Parameters:
- `N_BYTES`, 4, RAM word width in bytes
- `DEPTH`, 256, RAM words
- `ADDR_BITS`, `$clog2(DEPTH)`, address width
- `N_BITS`, `N_BYTES*8`, data width

Ports (requester ports repeat for `r0_` and `r1_`):
- `CLK`  in  1  single clock, rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `rN_wdata`  in  N_BITS  write data
- `rN_addr`  in  ADDR_BITS  word address
- `rN_byte_en`  in  N_BYTES  byte enables
- `rN_wen`, `rN_ren`  in  1  write / read strobes
- `rN_rdata`  out  N_BITS  read data, valid when `rN_busy`=0 with `rN_ren`=1
- `rN_busy`  out  1  access pending
- `ram_wdata`, `ram_addr`, `ram_byte_en`, `ram_wen`, `ram_ren`  out  to RAM
- `ram_rdata`  in  N_BITS; `ram_busy`  in  1  from RAM

## Operation
- Request `reqN = rN_wen | rN_ren`. A requester holds its strobes, address and data stable until its `busy` is 0.
- States: IDLE, LOCKED. A `owner` flop holds the locked requester. A `last` flop holds the requester served most recently.
- IDLE:
  - `pick` is combinational: the only requester asserting, else the priority winner.
  - RAM ports are driven from `pick` in the same cycle.
  - If `ram_busy`=0, the access completes this cycle and the state stays IDLE.
  - If `ram_busy`=1, go to LOCKED with `owner<=pick`.
- LOCKED:
  - RAM ports are driven from `owner`.
  - When `ram_busy`=0 the access completes and the next state is IDLE.
  - If the owner drops its request (protocol violation), go to IDLE next cycle and do not report a completion.
- Completion: `last<=winner`.
- Busy: `rN_busy = reqN & ~(grantedN & ~ram_busy)`. A non-requesting port sees `busy`=0.
- `ram_rdata` is broadcast to both `rN_rdata`.
- With no request, all RAM strobes are 0 and the RAM data, address and byte-enable outputs are 0.
- `wen` and `ren` are forwarded unmodified. Asserting both is illegal upstream.

## Timing
- Reset: state=IDLE, `owner`=0, `last`=1, so r0 wins the first contention.
- Reset mid-access drops the lock, so all RAM strobes are 0 immediately. The RAM is assumed to be reset by the same `nRST`.
- Zero-latency RAM: completion in the request cycle, `busy`=0 that cycle.
- RAM latency L: requester `busy` stays high for L cycles; data is returned in cycle L+1.
- Back-to-back: a new arbitration happens in the IDLE cycle right after completion. No dead cycle is inserted.
- A losing requester keeps `busy`=1 for the whole winner transaction plus its own.

## Configuration
- `CONFIG_RAM_ARB_RR_EN` defined: round-robin. On contention, the requester not equal to `last` wins.
- Undefined: fixed priority. r0 always wins contention, and `last` is not instantiated.

## Structure
- Package `config_ram_arb_pkg`: state enum `arb_state_t` {IDLE, LOCKED} and requester index typedef `req_id_t` (1 bit).
- Sub-module `config_ram_arb_pick`: combinational winner selection from `req0`, `req1` and `last`. It contains the macro-dependent logic only.

## Test plan
- Zero-latency RAM, r0 read addr 0x10 alone → `ram_ren`=1 and `ram_addr`=0x10 same cycle; `r0_busy`=0; `r0_rdata` equals the stored word.
- LAT=2 RAM, r0 and r1 both write in cycle 0 → r0 granted; `r1_busy`=1 until r0 completes; r1 is serviced from the next cycle.
- Under `CONFIG_RAM_ARB_RR_EN`, continuous requests from both sides → grants alternate r0, r1, r0, r1. Without the macro → r0 every time.
- Locked r1 write, r0 asserts mid-access → RAM address and data stay r1's until `ram_busy` falls.
- `nRST` pulse during LOCKED → all RAM strobes 0, state IDLE, r0 wins the next contention.
- Owner drops `ren` in LOCKED → returns to IDLE next cycle with no `busy`=0 completion reported to the owner.
